// File: rtl/online_pkg.sv
// Shared definitions for radix-2 online arithmetic: digit encoding, converter FSM states,
// and the on-the-fly conversion step used by converters and reference models.
package online_pkg;

    localparam logic [1:0] DIG_POS   = 2'b10;
    localparam logic [1:0] DIG_NEG   = 2'b01;
    localparam int         OTF_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_COLLECT,
        ST_DONE
    } otf_state_e;

    typedef struct packed {
        logic [OTF_MAX_W-1:0] q;
        logic [OTF_MAX_W-1:0] qm;
    } otf_pair_t;

    // Callers truncate to their own width; dropping the MSBs keeps the sign correct.
    function automatic otf_pair_t otf_step(input logic [OTF_MAX_W-1:0] q,
                                           input logic [OTF_MAX_W-1:0] qm,
                                           input logic zp,
                                           input logic zn);
        otf_pair_t r;
        case ({zp, zn})
            DIG_POS: begin
                r.q  = {q[OTF_MAX_W-2:0], 1'b1};
                r.qm = {q[OTF_MAX_W-2:0], 1'b0};
            end
            DIG_NEG: begin
                r.q  = {qm[OTF_MAX_W-2:0], 1'b1};
                r.qm = {qm[OTF_MAX_W-2:0], 1'b0};
            end
            default: begin
                r.q  = {q[OTF_MAX_W-2:0], 1'b0};
                r.qm = {qm[OTF_MAX_W-2:0], 1'b1};
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/online_otf_converter_if.sv
// Digit-stream input and parallel-result output of the on-the-fly converter.
interface online_otf_converter_if #(
    parameter int OUT_DIGITS = 5
);
    logic                  start;
    logic                  zp;
    logic                  zn;
    logic [OUT_DIGITS:0]   result;
    logic                  result_valid;
    logic                  busy;

    modport master (
        output start, zp, zn,
        input  result, result_valid, busy
    );

    modport slave (
        input  start, zp, zn,
        output result, result_valid, busy
    );
endinterface

// File: rtl/online_otf_converter.sv
// Converts an MSB-first signed-digit stream into two's complement with Q/QM on-the-fly registers.
// Result appears one cycle after the last digit; no backpressure, start is ignored while busy.
module online_otf_converter
    import online_pkg::*;
#(
    parameter int OUT_DIGITS = 5,
    parameter int DELTA      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    online_otf_converter_if.slave   bus
);

    localparam int W   = OUT_DIGITS + 1;
    localparam int DCW = (OUT_DIGITS > 1) ? $clog2(OUT_DIGITS) : 1;

    otf_state_e         r_state;
    otf_state_e         w_state_nxt;
    logic [3:0]         r_skip_cnt;
    logic [DCW-1:0]     r_dig_cnt;
    logic [W-1:0]       r_q;
    logic [W-1:0]       r_qm;
    logic [W-1:0]       r_result;
    logic               w_enter_collect;
    logic               w_last_digit;
    logic               w_accept_start;
    otf_pair_t          w_step;
    logic               w_unused;

    assign w_last_digit   = (r_dig_cnt == DCW'(OUT_DIGITS - 1));
    assign w_accept_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
    assign w_step         = otf_step(OTF_MAX_W'(r_q), OTF_MAX_W'(r_qm), bus.zp, bus.zn);
    assign w_unused       = &{1'b0, w_step.q[OTF_MAX_W-1:W], w_step.qm[OTF_MAX_W-1:W]};

    // r_skip_cnt holds the number of SKIP cycles still to spend, this one included.
    always_comb begin
        w_state_nxt     = r_state;
        w_enter_collect = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (DELTA == 1) begin
                        w_state_nxt     = ST_COLLECT;
                        w_enter_collect = 1'b1;
                    end else begin
                        w_state_nxt = ST_SKIP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (r_skip_cnt == 4'd1) begin
                    w_state_nxt     = ST_COLLECT;
                    w_enter_collect = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (w_last_digit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skip_cnt <= '0;
            r_dig_cnt  <= '0;
            r_q        <= '0;
            r_qm       <= '1;
            r_result   <= '0;
        end else begin
            if (w_accept_start) begin
                r_skip_cnt <= 4'(DELTA - 1);
            end else if (r_state == ST_SKIP) begin
                r_skip_cnt <= r_skip_cnt - 4'd1;
            end

            if (w_enter_collect) begin
                r_dig_cnt <= '0;
                r_q       <= '0;
                r_qm      <= '1;
            end else if (r_state == ST_COLLECT) begin
                r_dig_cnt <= r_dig_cnt + DCW'(1);
                r_q       <= w_step.q[W-1:0];
                r_qm      <= w_step.qm[W-1:0];
                if (w_last_digit) begin
                    r_result <= w_step.q[W-1:0];
                end
            end
        end
    end

    assign bus.result       = r_result;
    assign bus.result_valid = (r_state == ST_DONE);
    assign bus.busy         = (r_state == ST_SKIP) || (r_state == ST_COLLECT);

endmodule

// File: tb/tb_online_otf_converter.sv
// Scoreboard bench: the driver queues expected results, a negedge monitor checks them.
module tb_online_otf_converter;

    localparam int N = 5;
    localparam int D = 2;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    online_otf_converter_if #(.OUT_DIGITS(N)) bus();

    online_otf_converter #(.OUT_DIGITS(N), .DELTA(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    logic exp_busy = 1'b0;
    logic chk_busy = 1'b0;
    logic prev_vld = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (bus.result_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", $signed(bus.result), e.val);
                    check("valid_cycle", cyc, e.cyc);
                end
                check("valid_width", prev_vld, 0);
            end
            if (chk_busy) check("busy", bus.busy, exp_busy);
            prev_vld = bus.result_valid;
        end else begin
            prev_vld = 1'b0;
        end
    end

    function automatic int enc_value(input logic [2*N-1:0] enc);
        int v = 0;
        logic [1:0] p;
        for (int k = 0; k < N; k++) begin
            p = enc[2*(N-1-k) +: 2];
            v = v * 2 + ((p == 2'b10) ? 1 : (p == 2'b01) ? -1 : 0);
        end
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    // Starts in the current cycle and returns in the DONE cycle, so a following call is back-to-back.
    task automatic run_conv(input logic [2*N-1:0] enc, input int exp_val, input bit extra_starts);
        sb_q.push_back('{exp_val, cyc + D + N});
        bus.start = 1'b1;
        exp_busy  = 1'b0;
        bus.zp    = 1'($urandom);
        bus.zn    = 1'($urandom);
        for (int i = 0; i < D; i++) begin
            @(posedge clock); #1;
            bus.start = extra_starts;
            exp_busy  = 1'b1;
            bus.zp    = 1'($urandom);
            bus.zn    = 1'($urandom);
        end
        for (int k = 0; k < N; k++) begin
            {bus.zp, bus.zn} = enc[2*(N-1-k) +: 2];
            @(posedge clock); #1;
            bus.start = extra_starts;
        end
        bus.start = 1'b0;
        exp_busy  = 1'b0;
        bus.zp    = 1'($urandom);
        bus.zn    = 1'($urandom);
    endtask

    initial begin
        logic [2*N-1:0] enc;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.zp    = 1'b0;
        bus.zn    = 1'b0;
        #1;
        check("reset_result", bus.result, 0);
        check("reset_valid", bus.result_valid, 0);
        check("reset_busy", bus.busy, 0);
        @(posedge clock);
        @(posedge clock); #1;
        reset    = 1'b0;
        chk_busy = 1'b1;
        idle(1);

        run_conv({2'b10, 2'b00, 2'b01, 2'b10, 2'b01}, 13, 1'b0);
        idle(3);
        check("result_hold", $signed(bus.result), 13);
        run_conv({2'b01, 2'b00, 2'b00, 2'b00, 2'b00}, -16, 1'b0);
        idle(1);
        run_conv({2'b10, 2'b10, 2'b10, 2'b10, 2'b10}, 31, 1'b0);
        idle(2);
        run_conv({2'b01, 2'b01, 2'b01, 2'b01, 2'b01}, -31, 1'b0);
        idle(1);
        run_conv({2'b11, 2'b11, 2'b11, 2'b11, 2'b11}, 0, 1'b0);
        idle(1);
        run_conv({2'b10, 2'b11, 2'b01, 2'b11, 2'b10}, 13, 1'b0);
        idle(1);

        run_conv({2'b10, 2'b00, 2'b01, 2'b10, 2'b01}, 13, 1'b0);
        run_conv({2'b01, 2'b01, 2'b01, 2'b01, 2'b01}, -31, 1'b1);
        run_conv({2'b00, 2'b10, 2'b00, 2'b10, 2'b01}, 9, 1'b1);
        idle(2);

        // Asynchronous reset while digit 2 is on the rails.
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        exp_busy  = 1'b1;
        repeat (D - 1) begin
            @(posedge clock); #1;
        end
        {bus.zp, bus.zn} = 2'b10;
        @(posedge clock); #1;
        {bus.zp, bus.zn} = 2'b01;
        @(posedge clock); #1;
        {bus.zp, bus.zn} = 2'b10;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_result", bus.result, 0);
        check("async_rst_valid", bus.result_valid, 0);
        check("async_rst_busy", bus.busy, 0);
        exp_busy = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        idle(D + N + 1);
        check("post_rst_result", bus.result, 0);
        run_conv({2'b00, 2'b00, 2'b00, 2'b00, 2'b10}, 1, 1'b0);
        idle(1);

        repeat (300) begin
            for (int k = 0; k < N; k++) enc[2*k +: 2] = 2'($urandom_range(0, 3));
            run_conv(enc, enc_value(enc), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(D + N + 3);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
